// File: rtl/fp_pkg.sv
// Shared constants and FSM encoding for the single-precision FP datapath.
package fp_pkg;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;
  localparam int QBITS    = MAN_W + 2;

  localparam logic [31:0]      QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_NORM,
    S_DONE
  } state_t;
endpackage

// File: rtl/fp_div_step.sv
// One restoring-division iteration: conditional subtract of the divisor, then shift.
module fp_div_step
  import fp_pkg::*;
(
  input  logic [MAN_W+1:0] rem_in,
  input  logic [MAN_W:0]   divisor,
  output logic [MAN_W+1:0] rem_out,
  output logic             q_bit
);
  logic [MAN_W+1:0] divisor_ext;
  logic [MAN_W+1:0] diff;

  assign divisor_ext = {1'b0, divisor};
  assign q_bit       = (rem_in >= divisor_ext);
  assign diff        = rem_in - divisor_ext;
  assign rem_out     = (q_bit ? diff : rem_in) << 1;
endmodule

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider, c = a / b, one quotient bit per clock.
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] c
);
  localparam int MW = MAN_W + 1;
  localparam int RW = MAN_W + 2;

  state_t               state;
  logic [31:0]          a_r, b_r;
  logic                 sign_r;
  logic [EXP_W-1:0]     ea_r, eb_r;
  logic [MW-1:0]        man_b_r;
  logic [RW-1:0]        rem_r, q_r;
  logic [4:0]           cnt_r;

  logic [RW-1:0]        rem_nxt;
  logic                 q_bit;

  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  logic                 sgn;
  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                 spec_hit;
  logic [31:0]          spec_c;

  logic signed [9:0]    exp_n;
  logic [MAN_W-1:0]     frac_n;

  function automatic logic [31:0] pack_result(input logic s, input logic signed [9:0] e,
                                              input logic [MAN_W-1:0] f);
    if (e >= 10'sd255)
      return {s, EXP_MAX, {MAN_W{1'b0}}};
    else if (e <= 10'sd0)
      return {s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    else
      return {s, e[EXP_W-1:0], f};
  endfunction

  fp_div_step u_step (
    .rem_in  (rem_r),
    .divisor (man_b_r),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // Unpack and special-case classification of the registered operands
  always_comb begin
    ea     = a_r[30:23];
    eb     = b_r[30:23];
    fa     = a_r[22:0];
    fb     = b_r[22:0];
    sgn    = a_r[31] ^ b_r[31];
    a_nan  = (ea == EXP_MAX) && (fa != '0);
    b_nan  = (eb == EXP_MAX) && (fb != '0);
    a_inf  = (ea == EXP_MAX) && (fa == '0);
    b_inf  = (eb == EXP_MAX) && (fb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);

    spec_hit = 1'b1;
    spec_c   = QNAN;
    if (a_nan || b_nan)
      spec_c = QNAN;
    else if ((a_inf && b_inf) || (a_zero && b_zero))
      spec_c = QNAN;
    else if (a_inf || b_zero)
      spec_c = {sgn, EXP_MAX, {MAN_W{1'b0}}};
    else if (a_zero || b_inf)
      spec_c = {sgn, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    else
      spec_hit = 1'b0;
  end

  // Normalise: quotient lies in [0.5, 2); a leading 0 costs one exponent step
  always_comb begin
    exp_n = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + $signed(10'(EXP_BIAS));
    if (q_r[RW-1]) begin
      frac_n = q_r[RW-2:1];
    end else begin
      frac_n = q_r[RW-3:0];
      exp_n  = exp_n - 10'sd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sign_r  <= 1'b0;
      ea_r    <= '0;
      eb_r    <= '0;
      man_b_r <= '0;
      rem_r   <= '0;
      q_r     <= '0;
      cnt_r   <= '0;
      c       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // done high means this is the completion cycle, where start is ignored
          if (start && !done) begin
            a_r   <= a;
            b_r   <= b;
            busy  <= 1'b1;
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_r  <= sgn;
          ea_r    <= ea;
          eb_r    <= eb;
          man_b_r <= {1'b1, fb};
          rem_r   <= {1'b0, 1'b1, fa};
          q_r     <= '0;
          cnt_r   <= '0;
          if (spec_hit) begin
            c     <= spec_c;
            state <= S_DONE;
          end else begin
            state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem_r <= rem_nxt;
          q_r   <= {q_r[RW-2:0], q_bit};
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'(QBITS - 1))
            state <= S_NORM;
        end
        S_NORM: begin
          c     <= pack_result(sign_r, exp_n, frac_n);
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
